// File: rtl/fwd_pkg.sv
// Shared types for the forwarding/hazard controller: select codes, FSM states, shadow entries.
package fwd_pkg;

  localparam int REG_W = 5;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    STALLED = 2'd1,
    FROZEN  = 2'd2
  } state_e;

  typedef struct packed {
    logic [REG_W-1:0] rd;
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
    logic             rw;
    logic             mr;
  } idex_t;

  typedef struct packed {
    logic [REG_W-1:0] rd;
    logic             rw;
  } stage_t;

  localparam idex_t IDEX_BUBBLE = '0;

endpackage

// File: rtl/fwd_sel_dec.sv
// Priority decode of one EX operand select; pure combinational, no flow control.
// The EX/MEM match wins over MEM/WB so the youngest value reaches the ALU; x0 never forwards.
module fwd_sel_dec
  import fwd_pkg::*;
#(
  parameter int W = REG_W
) (
  input  logic [W-1:0] src,
  input  logic [W-1:0] exmem_rd,
  input  logic         exmem_rw,
  input  logic [W-1:0] memwb_rd,
  input  logic         memwb_rw,
  output logic [1:0]   sel
);

  always_comb begin
    sel = FWD_REG;
    if (exmem_rw && (exmem_rd != '0) && (exmem_rd == src))
      sel = FWD_MEM;
    else if (memwb_rw && (memwb_rd != '0) && (memwb_rd == src))
      sel = FWD_WB;
  end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding selects and stall/flush/hold generation from a shadow of ID/EX, EX/MEM, MEM/WB.
// Selects are one flop deep; stall/flush/hold are same-cycle combinational; mem_busy freezes everything.
module fwd_hazard_ctrl
  import fwd_pkg::*;
#(
  parameter int REG_ADDR_W = REG_W,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  input  logic                  ex_branch_taken,
  input  logic                  mem_busy,
  output logic [1:0]            fwd_a_sel,
  output logic [1:0]            fwd_b_sel,
  output logic                  stall,
  output logic                  flush,
  output logic                  hold,
  output logic [CNT_W-1:0]      stall_cnt
);

  idex_t  idex;
  stage_t exmem;
  stage_t memwb;
  state_e state_q;
  state_e state_d;
  logic   load_use;

  assign load_use = idex.mr && (idex.rd != '0) && id_valid &&
                    ((idex.rd == id_rs1) || (idex.rd == id_rs2));

  always_ff @(posedge clk) begin
    if (reset) state_q <= RUN;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = RUN;
    if (mem_busy)   state_d = FROZEN;
    else if (stall) state_d = STALLED;
  end

  // The bubble just inserted means a load-use cannot recur in STALLED; gating on it makes that explicit.
  always_comb begin
    hold  = 1'b0;
    flush = 1'b0;
    stall = 1'b0;
    if (!reset) begin
      if (mem_busy)                              hold  = 1'b1;
      else if (ex_branch_taken)                  flush = 1'b1;
      else if (load_use && state_q != STALLED)   stall = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idex  <= IDEX_BUBBLE;
      exmem <= '0;
      memwb <= '0;
    end else if (!mem_busy) begin
      memwb <= exmem;
      exmem <= '{rd: idex.rd, rw: idex.rw};
      if (flush || stall || !id_valid)
        idex <= IDEX_BUBBLE;
      else
        idex <= '{rd: id_rd, rs1: id_rs1, rs2: id_rs2, rw: id_reg_write, mr: id_mem_read};
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      stall_cnt <= '0;
    else if (stall && (stall_cnt != {CNT_W{1'b1}}))
      stall_cnt <= stall_cnt + CNT_W'(1);
  end

  fwd_sel_dec #(.W(REG_W)) u_dec_a (
    .src      (idex.rs1),
    .exmem_rd (exmem.rd),
    .exmem_rw (exmem.rw),
    .memwb_rd (memwb.rd),
    .memwb_rw (memwb.rw),
    .sel      (fwd_a_sel)
  );

  fwd_sel_dec #(.W(REG_W)) u_dec_b (
    .src      (idex.rs2),
    .exmem_rd (exmem.rd),
    .exmem_rw (exmem.rw),
    .memwb_rd (memwb.rd),
    .memwb_rw (memwb.rw),
    .sel      (fwd_b_sel)
  );

endmodule
